// File: rtl/pll_reset_sequencer.sv
// ----------------------------------------------------------------------------
// PllResetSequencer (module pll_reset_sequencer)
//
// Supervises the system PLL fed by the 74.25 MHz reference. It pulses the PLL
// reset, waits for a synchronised and debounced lock, then releases the
// downstream domain resets one after another. It watches for lock loss and
// restarts the sequence. A bounded number of lock timeouts is retried before
// a sticky fault is raised.
//
// Ports:
//   clk_74a          in   reference clock, the only clock of this block
//   reset_n          in   asynchronous active-low reset
//   pll_locked       in   PLL lock flag, asynchronous to clk_74a
//   restart_req      in   single-cycle request to restart the whole sequence
//   pll_rst          out  active-high PLL reset
//   dom_rst_n        out  active-low domain resets, released LSB first
//   ready            out  all domains released with lock stable
//   fault            out  retries exhausted, sticky until restart_req
//   retry_cnt        out  lock attempts consumed in the current sequence
//   lock_loss_cnt    out  (stats build) saturating count of lock losses
//   last_lock_cycles out  (stats build) timeout count captured at release
//
// Optional feature macro: PLL_RESET_SEQUENCER_STATS_EN
//   When defined, adds lock_loss_cnt and last_lock_cycles.
// ----------------------------------------------------------------------------
module pll_reset_sequencer #(
   parameter int NUM_DOMAINS    = 4,
   parameter int PLL_RST_CYCLES = 16,
   parameter int LOCK_TIMEOUT   = 65536,
   parameter int LOCK_STABLE    = 1024,
   parameter int STAGGER_CYCLES = 64,
   parameter int MAX_RETRIES    = 7,
   localparam int RETRY_W       = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
   input  logic                   clk_74a,
   input  logic                   reset_n,
   input  logic                   pll_locked,
   input  logic                   restart_req,
   output logic                   pll_rst,
   output logic [NUM_DOMAINS-1:0] dom_rst_n,
   output logic                   ready,
   output logic                   fault,
   output logic [RETRY_W-1:0]     retry_cnt
`ifdef PLL_RESET_SEQUENCER_STATS_EN
   ,
   output logic [7:0]             lock_loss_cnt,
   output logic [15:0]            last_lock_cycles
`endif
);

   // Counter widths are sized so each counter can hold its terminal value
   // without wrapping before the terminal compare.
   localparam int RST_W   = $clog2(PLL_RST_CYCLES + 1);
   localparam int TMO_W   = $clog2(LOCK_TIMEOUT + 1);
   localparam int STB_W   = $clog2(LOCK_STABLE + 1);
   localparam int REL_MAX = (NUM_DOMAINS - 1) * STAGGER_CYCLES + 1;
   localparam int REL_W   = $clog2(REL_MAX + 1);

   typedef enum logic [2:0] {
      ST_PLL_RST   = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_DEBOUNCE  = 3'd2,
      ST_RELEASE   = 3'd3,
      ST_RUN       = 3'd4,
      ST_FAULT     = 3'd5
   } state_t;

   state_t                 state_q, state_d;
   logic                   lkMeta_q;
   logic                   lk_q;
   logic [RST_W-1:0]       rstCnt_q, rstCnt_d;
   logic [TMO_W-1:0]       tmoCnt_q, tmoCnt_d;
   logic [STB_W-1:0]       stbCnt_q, stbCnt_d;
   logic [REL_W-1:0]       relCnt_q, relCnt_d;
   logic [RETRY_W-1:0]     retry_q, retry_d;
   logic                   pllRst_q, pllRst_d;
   logic [NUM_DOMAINS-1:0] domRst_q, domRst_d;
   logic                   ready_q, ready_d;
   logic                   fault_q, fault_d;

   // Two-flop synchroniser for the asynchronous lock flag. lk_q is the only
   // version of the lock flag the state machine ever looks at.
   always_ff @(posedge clk_74a or negedge reset_n) begin
      if (!reset_n) begin
         lkMeta_q <= 1'b0;
         lk_q     <= 1'b0;
      end else begin
         lkMeta_q <= pll_locked;
         lk_q     <= lkMeta_q;
      end
   end

   // State, counters and every output are registered here so that the
   // outputs leaving the block cannot glitch.
   always_ff @(posedge clk_74a or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_PLL_RST;
         rstCnt_q <= '0;
         tmoCnt_q <= '0;
         stbCnt_q <= '0;
         relCnt_q <= '0;
         retry_q  <= '0;
         pllRst_q <= 1'b1;
         domRst_q <= '0;
         ready_q  <= 1'b0;
         fault_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         rstCnt_q <= rstCnt_d;
         tmoCnt_q <= tmoCnt_d;
         stbCnt_q <= stbCnt_d;
         relCnt_q <= relCnt_d;
         retry_q  <= retry_d;
         pllRst_q <= pllRst_d;
         domRst_q <= domRst_d;
         ready_q  <= ready_d;
         fault_q  <= fault_d;
      end
   end

   // Next-state logic. Priority is restart request, then lock loss, then
   // lock timeout, then normal progression. Every path that re-enters the
   // PLL reset state clears all counters so the new attempt starts clean.
   always_comb begin
      state_d  = state_q;
      rstCnt_d = rstCnt_q;
      tmoCnt_d = tmoCnt_q;
      stbCnt_d = stbCnt_q;
      relCnt_d = relCnt_q;
      retry_d  = retry_q;
      pllRst_d = pllRst_q;
      domRst_d = domRst_q;
      ready_d  = ready_q;
      fault_d  = fault_q;

      if (restart_req) begin
         state_d  = ST_PLL_RST;
         rstCnt_d = '0;
         tmoCnt_d = '0;
         stbCnt_d = '0;
         relCnt_d = '0;
         retry_d  = '0;
         pllRst_d = 1'b1;
         domRst_d = '0;
         ready_d  = 1'b0;
         fault_d  = 1'b0;
      end else begin
         case (state_q)
            ST_PLL_RST: begin
               pllRst_d = 1'b1;
               if (int'(rstCnt_q) >= PLL_RST_CYCLES - 1) begin
                  state_d  = ST_WAIT_LOCK;
                  pllRst_d = 1'b0;
                  rstCnt_d = '0;
                  tmoCnt_d = '0;
                  stbCnt_d = '0;
               end else begin
                  rstCnt_d = rstCnt_q + RST_W'(1);
               end
            end

            // The timeout counter runs across both waiting states, so a
            // bouncing lock cannot postpone the timeout indefinitely.
            ST_WAIT_LOCK, ST_DEBOUNCE: begin
               tmoCnt_d = tmoCnt_q + TMO_W'(1);
               if (int'(tmoCnt_q) >= LOCK_TIMEOUT - 1) begin
                  tmoCnt_d = '0;
                  stbCnt_d = '0;
                  rstCnt_d = '0;
                  pllRst_d = 1'b1;
                  if (int'(retry_q) < MAX_RETRIES) begin
                     state_d = ST_PLL_RST;
                     retry_d = retry_q + RETRY_W'(1);
                  end else begin
                     state_d = ST_FAULT;
                     fault_d = 1'b1;
                  end
               end else if (state_q == ST_WAIT_LOCK) begin
                  if (lk_q) begin
                     state_d  = ST_DEBOUNCE;
                     stbCnt_d = '0;
                  end
               end else begin
                  if (!lk_q) begin
                     state_d  = ST_WAIT_LOCK;
                     stbCnt_d = '0;
                  end else if (int'(stbCnt_q) >= LOCK_STABLE - 1) begin
                     state_d  = ST_RELEASE;
                     stbCnt_d = '0;
                     relCnt_d = '0;
                  end else begin
                     stbCnt_d = stbCnt_q + STB_W'(1);
                  end
               end
            end

            // Bit i rises when the release counter equals i*STAGGER_CYCLES.
            // Bits are only ever set here, in ascending order, so a higher
            // domain can never come out of reset before a lower one.
            ST_RELEASE: begin
               if (!lk_q) begin
                  state_d  = ST_PLL_RST;
                  rstCnt_d = '0;
                  tmoCnt_d = '0;
                  stbCnt_d = '0;
                  relCnt_d = '0;
                  retry_d  = '0;
                  pllRst_d = 1'b1;
                  domRst_d = '0;
                  ready_d  = 1'b0;
               end else if (domRst_q[NUM_DOMAINS-1]) begin
                  state_d  = ST_RUN;
                  ready_d  = 1'b1;
                  relCnt_d = '0;
               end else begin
                  for (int i = 0; i < NUM_DOMAINS; i++) begin
                     if (int'(relCnt_q) == i * STAGGER_CYCLES) begin
                        domRst_d[i] = 1'b1;
                     end
                  end
                  relCnt_d = relCnt_q + REL_W'(1);
               end
            end

            // A lock loss after a good lock is a fresh start, not a retry,
            // so the retry count is cleared.
            ST_RUN: begin
               if (!lk_q) begin
                  state_d  = ST_PLL_RST;
                  rstCnt_d = '0;
                  tmoCnt_d = '0;
                  stbCnt_d = '0;
                  relCnt_d = '0;
                  retry_d  = '0;
                  pllRst_d = 1'b1;
                  domRst_d = '0;
                  ready_d  = 1'b0;
               end
            end

            ST_FAULT: begin
               pllRst_d = 1'b1;
               domRst_d = '0;
               ready_d  = 1'b0;
               fault_d  = 1'b1;
            end

            default: begin
               state_d  = ST_PLL_RST;
               rstCnt_d = '0;
               pllRst_d = 1'b1;
               domRst_d = '0;
               ready_d  = 1'b0;
            end
         endcase
      end
   end

   assign pll_rst   = pllRst_q;
   assign dom_rst_n = domRst_q;
   assign ready     = ready_q;
   assign fault     = fault_q;
   assign retry_cnt = retry_q;

`ifdef PLL_RESET_SEQUENCER_STATS_EN
   logic       lockLoss;
   logic       enterRelease;
   logic [7:0] lockLossCnt_q;
   logic [15:0] lastLock_q;

   // A restart request on the same edge wins over the lock loss, so that
   // case is not counted as a loss.
   assign lockLoss     = ((state_q == ST_RELEASE) || (state_q == ST_RUN)) &&
                         !lk_q && !restart_req;
   assign enterRelease = (state_q == ST_DEBOUNCE) && (state_d == ST_RELEASE);

   // Statistics survive restart requests; only reset_n clears them.
   always_ff @(posedge clk_74a or negedge reset_n) begin
      if (!reset_n) begin
         lockLossCnt_q <= '0;
         lastLock_q    <= '0;
      end else begin
         if (lockLoss && (lockLossCnt_q != 8'hFF)) begin
            lockLossCnt_q <= lockLossCnt_q + 8'd1;
         end
         if (enterRelease) begin
            lastLock_q <= 16'(tmoCnt_d);
         end
      end
   end

   assign lock_loss_cnt    = lockLossCnt_q;
   assign last_lock_cycles = lastLock_q;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// ----------------------------------------------------------------------------
// Directed self-checking bench for pll_reset_sequencer, using small parameter
// values so every phase completes in a few dozen clocks.
// ----------------------------------------------------------------------------
module tb_pll_reset_sequencer;

   localparam int NUM_DOMAINS    = 4;
   localparam int PLL_RST_CYCLES = 4;
   localparam int LOCK_TIMEOUT   = 50;
   localparam int LOCK_STABLE    = 8;
   localparam int STAGGER_CYCLES = 3;
   localparam int MAX_RETRIES    = 2;

   logic       clock;
   logic       reset_n;
   logic       pll_locked;
   logic       restart_req;
   logic       pll_rst;
   logic [3:0] dom_rst_n;
   logic       ready;
   logic       fault;
   logic [1:0] retry_cnt;
`ifdef PLL_RESET_SEQUENCER_STATS_EN
   logic [7:0]  lock_loss_cnt;
   logic [15:0] last_lock_cycles;
`endif

   int testCount = 0;
   int failCount = 0;

   pll_reset_sequencer #(
      .NUM_DOMAINS   (NUM_DOMAINS),
      .PLL_RST_CYCLES(PLL_RST_CYCLES),
      .LOCK_TIMEOUT  (LOCK_TIMEOUT),
      .LOCK_STABLE   (LOCK_STABLE),
      .STAGGER_CYCLES(STAGGER_CYCLES),
      .MAX_RETRIES   (MAX_RETRIES)
   ) dut (
      .clk_74a    (clock),
      .reset_n    (reset_n),
      .pll_locked (pll_locked),
      .restart_req(restart_req),
      .pll_rst    (pll_rst),
      .dom_rst_n  (dom_rst_n),
      .ready      (ready),
      .fault      (fault),
      .retry_cnt  (retry_cnt)
`ifdef PLL_RESET_SEQUENCER_STATS_EN
      ,
      .lock_loss_cnt   (lock_loss_cnt),
      .last_lock_cycles(last_lock_cycles)
`endif
   );

   // 10-time-unit clock; the DUT uses posedges, the bench works on negedges.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Compare one observed value against its hand-computed expectation.
   task automatic checkOutput(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
      testCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Advance n clocks, landing on a negedge.
   task automatic applyStimulus(input int n);
      repeat (n) @(negedge clock);
   endtask

   // Count consecutive samples (from the current one) where pll_rst == lvl.
   task automatic measureLevel(input logic lvl, output int cnt);
      cnt = 0;
      while (pll_rst === lvl && cnt < 200) begin
         cnt++;
         @(negedge clock);
      end
   endtask

   // Wait for dom_rst_n[0] to rise, bounded.
   task automatic waitFirstRelease(input int limit, output int cnt);
      cnt = 0;
      while (dom_rst_n[0] !== 1'b1 && cnt < limit) begin
         @(negedge clock);
         cnt++;
      end
   endtask

   // Called at the sample where dom_rst_n first reads 0001.
   task automatic checkStagger(input string tag);
      checkOutput({tag, " dom0"}, 32'(dom_rst_n), 32'h1);
      applyStimulus(1);
      checkOutput({tag, " dom0 hold"}, 32'(dom_rst_n), 32'h1);
      applyStimulus(2);
      checkOutput({tag, " dom1"}, 32'(dom_rst_n), 32'h3);
      applyStimulus(3);
      checkOutput({tag, " dom2"}, 32'(dom_rst_n), 32'h7);
      applyStimulus(3);
      checkOutput({tag, " dom3"}, 32'(dom_rst_n), 32'hF);
      checkOutput({tag, " ready early"}, 32'(ready), 32'h0);
      applyStimulus(1);
      checkOutput({tag, " ready"}, 32'(ready), 32'h1);
      checkOutput({tag, " retry"}, 32'(retry_cnt), 32'h0);
      checkOutput({tag, " pll_rst"}, 32'(pll_rst), 32'h0);
   endtask

   initial begin
      int n;
      int rises;
      logic prevRst;
      logic sawDom;

      reset_n     = 1'b0;
      pll_locked  = 1'b0;
      restart_req = 1'b0;
      applyStimulus(2);

      // Reset values
      checkOutput("reset pll_rst", 32'(pll_rst), 32'h1);
      checkOutput("reset dom_rst_n", 32'(dom_rst_n), 32'h0);
      checkOutput("reset ready", 32'(ready), 32'h0);
      checkOutput("reset fault", 32'(fault), 32'h0);
      checkOutput("reset retry", 32'(retry_cnt), 32'h0);

      // Test 1: first lock, staggered release
      reset_n = 1'b1;
      applyStimulus(1);
      measureLevel(1'b1, n);
      checkOutput("t1 pll_rst after reset", 32'(n), 32'd3);
      applyStimulus(10);
      pll_locked = 1'b1;
      waitFirstRelease(40, n);
      checkOutput("t1 release latency", 32'((n >= 11) && (n <= 13)), 32'h1);
      checkStagger("t1");
`ifdef PLL_RESET_SEQUENCER_STATS_EN
      checkOutput("t1 loss cnt", 32'(lock_loss_cnt), 32'h0);
`endif

      // Test 4: lock loss in RUN, then a full re-release
      pll_locked = 1'b0;
      n = 0;
      while (dom_rst_n !== 4'h0 && n < 10) begin
         applyStimulus(1);
         n++;
      end
      checkOutput("t4 loss latency", 32'((n >= 2) && (n <= 3)), 32'h1);
      checkOutput("t4 ready drop", 32'(ready), 32'h0);
      checkOutput("t4 retry", 32'(retry_cnt), 32'h0);
      applyStimulus(1);
      checkOutput("t4 pll_rst", 32'(pll_rst), 32'h1);
      pll_locked = 1'b1;
      waitFirstRelease(100, n);
      checkOutput("t4 relock found", 32'(n < 100), 32'h1);
      checkStagger("t4");
`ifdef PLL_RESET_SEQUENCER_STATS_EN
      checkOutput("t4 loss cnt", 32'(lock_loss_cnt), 32'h1);
`endif

      // Test 5: restart request on the edge that sees the synced lock fall
      pll_locked = 1'b0;
      applyStimulus(2);
      restart_req = 1'b1;
      applyStimulus(1);
      restart_req = 1'b0;
      checkOutput("t5 dom", 32'(dom_rst_n), 32'h0);
      checkOutput("t5 ready", 32'(ready), 32'h0);
      checkOutput("t5 pll_rst", 32'(pll_rst), 32'h1);
      checkOutput("t5 retry", 32'(retry_cnt), 32'h0);
`ifdef PLL_RESET_SEQUENCER_STATS_EN
      checkOutput("t5 loss cnt", 32'(lock_loss_cnt), 32'h1);
`endif

      // Test 2: no lock at all -> three attempts then FAULT
      for (int a = 0; a < 3; a++) begin
         measureLevel(1'b1, n);
         checkOutput($sformatf("t2 pulse%0d", a), 32'(n), 32'd4);
         measureLevel(1'b0, n);
         checkOutput($sformatf("t2 wait%0d", a), 32'(n), 32'd50);
         checkOutput($sformatf("t2 retry%0d", a), 32'(retry_cnt),
                     (a == 2) ? 32'd2 : 32'(a + 1));
         checkOutput($sformatf("t2 fault%0d", a), 32'(fault),
                     (a == 2) ? 32'd1 : 32'd0);
      end
      applyStimulus(30);
      checkOutput("t2 stuck fault", 32'(fault), 32'h1);
      checkOutput("t2 stuck pll_rst", 32'(pll_rst), 32'h1);
      checkOutput("t2 stuck dom", 32'(dom_rst_n), 32'h0);
      restart_req = 1'b1;
      applyStimulus(1);
      restart_req = 1'b0;
      checkOutput("t2 restart fault", 32'(fault), 32'h0);
      checkOutput("t2 restart retry", 32'(retry_cnt), 32'h0);
      measureLevel(1'b1, n);
      checkOutput("t2 restart pulse", 32'(n), 32'd4);

      // Test 3: lock drops one clock in five -> never released, retries
      rises   = 0;
      sawDom  = 1'b0;
      prevRst = pll_rst;
      for (int k = 0; k < 170; k++) begin
         pll_locked = (k % 5) != 4;
         applyStimulus(1);
         if (pll_rst === 1'b1 && prevRst === 1'b0) rises++;
         if (dom_rst_n !== 4'h0) sawDom = 1'b1;
         prevRst = pll_rst;
      end
      checkOutput("t3 no release", 32'(sawDom), 32'h0);
      checkOutput("t3 pll_rst rises", 32'(rises), 32'd3);
      checkOutput("t3 fault", 32'(fault), 32'h1);
      checkOutput("t3 retry", 32'(retry_cnt), 32'd2);

      // Test 6: asynchronous reset in the middle of RELEASE
      pll_locked  = 1'b1;
      restart_req = 1'b1;
      applyStimulus(1);
      restart_req = 1'b0;
      checkOutput("t6 restart fault", 32'(fault), 32'h0);
      n = 0;
      while (dom_rst_n !== 4'h3 && n < 100) begin
         applyStimulus(1);
         n++;
      end
      checkOutput("t6 reached 0011", 32'(dom_rst_n), 32'h3);
      #2 reset_n = 1'b0;
      #1;
      checkOutput("t6 async pll_rst", 32'(pll_rst), 32'h1);
      checkOutput("t6 async dom", 32'(dom_rst_n), 32'h0);
      checkOutput("t6 async ready", 32'(ready), 32'h0);
      checkOutput("t6 async fault", 32'(fault), 32'h0);
      checkOutput("t6 async retry", 32'(retry_cnt), 32'h0);
`ifdef PLL_RESET_SEQUENCER_STATS_EN
      checkOutput("t6 async loss cnt", 32'(lock_loss_cnt), 32'h0);
`endif

      #20;
      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
